// File: rtl/cons.sv
// Buffered consumer: a DEPTH-entry FIFO drained by a two-state processor that spends
// PROC_CYCLES cycles per item. The optional histogram is enabled by defining CONS_HIST_EN.
module cons #(
  parameter int DEPTH       = 4,
  parameter int PROC_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic [7:0]              data,
  input  logic                    val,
  output logic                    rdy,
  output logic [$clog2(DEPTH):0]  level,
  output logic [15:0]             sum,
  output logic [7:0]              cnt,
  output logic [7:0]              last,
  output logic                    cons_val,
  output logic                    ovf,
`ifdef CONS_HIST_EN
  input  logic [2:0]              hist_sel,
  output logic [7:0]              hist_cnt,
`endif
  output logic                    state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(PROC_CYCLES) + 1;

  // Producer handshake: an item is taken on any edge with val=1 while rdy=1;
  // with rdy=0 it is dropped and ovf latches. There is no back-pressure wait.
  typedef enum logic {IDLE = 1'b0, PROC = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      work_q, work_d;
  logic [15:0]     sum_q;
  logic [7:0]      cnt_q, last_q;
  logic            cons_val_q, ovf_q;
  logic [7:0]      mem_q [DEPTH];
  logic            push, pop, commit;

  // Eligibility uses the pre-pop level, so a full FIFO rejects even while popping.
  assign rdy  = (level_q < LW'(DEPTH));
  assign push = val & rdy;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    work_d  = work_q;
    pop     = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          work_d  = mem_q[rd_ptr_q];
          timer_d = TW'(PROC_CYCLES - 1);
          state_d = PROC;
        end
      end
      PROC: begin
        if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      work_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      sum_q      <= '0;
      cnt_q      <= '0;
      last_q     <= '0;
      cons_val_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      work_q     <= work_d;
      cons_val_q <= commit;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !push) level_q <= level_q - 1'b1;
      if (val && !rdy) ovf_q <= 1'b1;
      if (commit) begin
        sum_q  <= sum_q + {8'd0, work_q};
        last_q <= work_q;
        if (cnt_q != 8'hff) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Storage is not reset; pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data;
  end

`ifdef CONS_HIST_EN
  logic [7:0] hist_q [7];
  logic [2:0] bucket;

  assign bucket = (work_q <= 8'd5) ? work_q[2:0] : 3'd6;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < 7; i++) hist_q[i] <= '0;
    end else if (commit && hist_q[bucket] != 8'hff) begin
      hist_q[bucket] <= hist_q[bucket] + 1'b1;
    end
  end

  always_comb begin
    hist_cnt = '0;
    if (hist_sel != 3'd7) hist_cnt = hist_q[hist_sel];
  end
`endif

  assign level     = level_q;
  assign sum       = sum_q;
  assign cnt       = cnt_q;
  assign last      = last_q;
  assign cons_val  = cons_val_q;
  assign ovf       = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_cons.sv
// Bench for cons: a queue-based reference model checked on every falling edge,
// plus directed scenarios with hand-computed expectations.
module tb_cons;
  localparam int DEPTH = 4;
  localparam int PROC_CYCLES = 3;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic [7:0]  data = '0;
  logic        val = 1'b0;
  logic        rdy;
  logic [$clog2(DEPTH):0] level;
  logic [15:0] sum;
  logic [7:0]  cnt, last;
  logic        cons_val, ovf, state_dbg;
`ifdef CONS_HIST_EN
  logic [2:0]  hist_sel = '0;
  logic [7:0]  hist_cnt;
`endif

  cons #(.DEPTH(DEPTH), .PROC_CYCLES(PROC_CYCLES)) dut (
    .clk(clk), .rst_b(rst_b), .data(data), .val(val), .rdy(rdy), .level(level),
    .sum(sum), .cnt(cnt), .last(last), .cons_val(cons_val), .ovf(ovf),
`ifdef CONS_HIST_EN
    .hist_sel(hist_sel), .hist_cnt(hist_cnt),
`endif
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: queue of held items, commit scheduled by cycle number
  logic [7:0]  m_q[$];
  bit          m_busy = 0;
  longint      m_cyc = 0;
  longint      m_done_at = 0;
  logic [7:0]  m_work = '0;
  logic [15:0] m_sum = '0;
  logic [7:0]  m_cnt = '0, m_last = '0;
  bit          m_cv = 0, m_ovf = 0;
  int          m_hist [7];

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_q.delete();
      m_busy = 0; m_sum = '0; m_cnt = '0; m_last = '0; m_cv = 0; m_ovf = 0;
      for (int i = 0; i < 7; i++) m_hist[i] = 0;
    end else begin
      bit can_push;
      m_cyc++;
      can_push = (m_q.size() < DEPTH);
      m_cv = 0;
      if (m_busy) begin
        if (m_cyc == m_done_at) begin
          m_sum  = m_sum + 16'(m_work);
          m_cnt  = (m_cnt == 8'd255) ? 8'd255 : m_cnt + 8'd1;
          m_last = m_work;
          m_cv   = 1;
          m_busy = 0;
          if (m_work <= 5) m_hist[m_work] = (m_hist[m_work] < 255) ? m_hist[m_work] + 1 : 255;
          else             m_hist[6]      = (m_hist[6] < 255) ? m_hist[6] + 1 : 255;
        end
      end else if (m_q.size() > 0) begin
        m_work    = m_q.pop_front();
        m_busy    = 1;
        m_done_at = m_cyc + PROC_CYCLES;
      end
      if (val) begin
        if (can_push) m_q.push_back(data);
        else          m_ovf = 1;
      end
    end
  end

  // scoreboard compare on every falling edge
  always @(negedge clk) begin
    chk("level", 32'(level), 32'(m_q.size()));
    chk("rdy", 32'(rdy), 32'(m_q.size() < DEPTH));
    chk("sum", 32'(sum), 32'(m_sum));
    chk("cnt", 32'(cnt), 32'(m_cnt));
    chk("last", 32'(last), 32'(m_last));
    chk("cons_val", 32'(cons_val), 32'(m_cv));
    chk("ovf", 32'(ovf), 32'(m_ovf));
`ifdef CONS_HIST_EN
    chk("hist_cnt", 32'(hist_cnt), (hist_sel == 3'd7) ? 32'd0 : 32'(m_hist[hist_sel]));
`endif
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    val = 1'b0;
    rst_b = 1'b0;
    step(); step();
    rst_b = 1'b1;
    step();
  endtask

  task automatic drain(input string name);
    bit done = 0;
    val = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (m_q.size() == 0 && !m_busy) begin
        done = 1;
        break;
      end
      step();
    end
    chk(name, 32'(done), 32'd1);
    step(); step();
  endtask

  initial begin
    int pushed;
    // reset values
    rst_b = 1'b0;
    step(); step();
    rst_b = 1'b1;
    step();
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cnt", 32'(cnt), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_rdy", 32'(rdy), 1);
    chk("rst_ovf", 32'(ovf), 0);

    // single item, latency
    data = 8'd5; val = 1'b1;
    step();
    val = 1'b0;
    chk("single_level_after_A", 32'(level), 1);
    step(); step(); step(); step();
    chk("single_cons_val", 32'(cons_val), 1);
    step();
    chk("single_cons_val_off", 32'(cons_val), 0);
    chk("single_sum", 32'(sum), 5);
    chk("single_cnt", 32'(cnt), 1);
    chk("single_last", 32'(last), 5);
    chk("single_level", 32'(level), 0);

    // continuous valid, overflow
    do_reset();
    data = 8'd1; val = 1'b1;
    repeat (20) step();
    chk("burst_level", 32'(level), 4);
    chk("burst_rdy", 32'(rdy), 0);
    chk("burst_ovf", 32'(ovf), 1);
    drain("burst_drain");
    chk("burst_ovf_sticky", 32'(ovf), 1);

    // 258 x 255 paced on rdy: sum wraps, cnt saturates
    do_reset();
    data = 8'd255;
    pushed = 0;
    for (int i = 0; i < 3000 && pushed < 258; i++) begin
      val = rdy;
      if (rdy) pushed++;
      step();
    end
    chk("sat_pushed", 32'(pushed), 258);
    drain("sat_drain");
    chk("sat_sum", 32'(sum), 254);
    chk("sat_cnt", 32'(cnt), 255);
    chk("sat_ovf", 32'(ovf), 0);

    // reset during processing
    do_reset();
    data = 8'd9; val = 1'b1;
    step();
    val = 1'b0;
    step(); step();
    chk("mid_state_proc", 32'(state_dbg), 1);
    rst_b = 1'b0;
    #1;
    chk("mid_rst_level", 32'(level), 0);
    step();
    rst_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("mid_no_cons_val", 32'(cons_val), 0);
    end
    chk("mid_sum", 32'(sum), 0);
    chk("mid_cnt", 32'(cnt), 0);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      val  = ($urandom_range(0, 99) < 40);
      data = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) data = 8'($urandom_range(0, 7));
`ifdef CONS_HIST_EN
      hist_sel = 3'($urandom_range(0, 7));
`endif
      if ($urandom_range(0, 299) == 0) rst_b = 1'b0;
      else rst_b = 1'b1;
      step();
    end
    rst_b = 1'b1;
    drain("rand_drain");

`ifdef CONS_HIST_EN
    do_reset();
    val = 1'b1;
    data = 8'd0; step();
    data = 8'd3; step();
    data = 8'd3; step();
    data = 8'd7; step();
    drain("hist_drain");
    hist_sel = 3'd3; #1; chk("hist_3", 32'(hist_cnt), 2);
    hist_sel = 3'd0; #1; chk("hist_0", 32'(hist_cnt), 1);
    hist_sel = 3'd6; #1; chk("hist_6", 32'(hist_cnt), 1);
    hist_sel = 3'd7; #1; chk("hist_7", 32'(hist_cnt), 0);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cons.md
CONS -- requirements
Module: cons

Interface
REQ-001 Parameter DEPTH, default 4, FIFO depth in entries; power of two, at least 2.
REQ-002 Parameter PROC_CYCLES, default 3, processing cycles per item; at least 1.
REQ-003 Port clk, input, 1 bit: clock, all state updates on the rising edge.
REQ-004 Port rst_b, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port data, input, 8 bits: producer value, sampled when val=1.
REQ-006 Port val, input, 1 bit: producer valid; may be asserted on every cycle with no wait.
REQ-007 Port rdy, output, 1 bit: space available, equal to (level < DEPTH), combinational from level.
REQ-008 Port level, output, clog2(DEPTH)+1 bits: FIFO occupancy, range 0..DEPTH.
REQ-009 Port sum, output, 16 bits: running sum of consumed values.
REQ-010 Port cnt, output, 8 bits: count of consumed items.
REQ-011 Port last, output, 8 bits: most recently consumed value.
REQ-012 Port cons_val, output, 1 bit: one-cycle pulse per consumed item.
REQ-013 Port ovf, output, 1 bit: sticky flag, set when a valid item is dropped.

Function
REQ-014 Accept: on an edge with val=1 and level<DEPTH, data SHALL be written at the FIFO tail.
REQ-015 Reject: on an edge with val=1 and level=DEPTH, data SHALL be dropped and ovf set to 1; ovf stays 1 until reset.
REQ-016 Push eligibility SHALL use level before the same-edge pop, so a full FIFO rejects even while popping.
REQ-017 Level: +1 on push only, -1 on pop only, unchanged on push and pop together; pointers wrap modulo DEPTH.
REQ-018 FSM SHALL have two states, IDLE and PROC.
REQ-019 IDLE with level>0: pop the head into a work register, load timer with PROC_CYCLES-1, go to PROC.
REQ-020 IDLE with level=0: remain in IDLE.
REQ-021 PROC with timer>0: decrement timer.
REQ-022 PROC with timer=0, commit on that edge and return to IDLE:
- sum <= sum + work, modulo 2^16 (wraps);
- cnt <= cnt+1, saturating at 255;
- last <= work;
- cons_val = 1 for the following cycle only.
REQ-023 Latency: an item pushed into an empty FIFO at edge A in IDLE SHALL be popped at A+1 and committed at A+1+PROC_CYCLES.
REQ-024 Throughput: at most one item per PROC_CYCLES+1 cycles.
REQ-025 A pop and a commit SHALL never occur on the same edge.
REQ-026 All 8-bit values are accepted, including values above 5.

Reset
REQ-027 rst_b=0 SHALL immediately clear:
- level, pointers, sum, cnt, last, cons_val, ovf and timer to 0;
- FSM state to IDLE;
- rdy therefore reads 1.
REQ-028 Reset during PROC SHALL discard the in-flight item and any FIFO contents, with no cons_val after release.
REQ-029 FIFO storage contents need not be cleared on reset.

Configuration
REQ-030 With macro CONS_HIST_EN defined, the following SHALL be added:
- input hist_sel, 3 bits, and output hist_cnt, 8 bits;
- seven 8-bit counters, saturating at 255 and cleared by reset;
- at each commit, bucket = work if work<=5, else bucket 6;
- hist_cnt = counter[hist_sel] combinationally, and 0 when hist_sel=7.
REQ-031 Without CONS_HIST_EN, the hist_sel/hist_cnt ports and the counters SHALL NOT exist; all other behaviour is identical.

Verification (DEPTH=4, PROC_CYCLES=3)
REQ-032 Hold rst_b=0, then release -> sum=0, cnt=0, last=0, cons_val=0, ovf=0, level=0, rdy=1.
REQ-033 Single val with data=5 at edge A -> level=1 after A, pop at A+1, cons_val high for the cycle after A+4; sum=5, cnt=1, last=5, level=0.
REQ-034 val=1 with data=1 on every cycle for 20 cycles -> level reaches 4, rdy=0, ovf=1 from the first rejected edge; sum increments by 1 every 4 cycles.
REQ-035 Feed 258 items of 255, pacing val on rdy -> sum=254 (65790 mod 65536), cnt=255 saturated, ovf=0.
REQ-036 Push 9, pulse rst_b low during PROC, release -> all outputs at reset values, and no cons_val for 10 cycles.
REQ-037 With CONS_HIST_EN, consume 0,3,3,7 -> hist_sel=3 gives 2, hist_sel=0 gives 1, hist_sel=6 gives 1, hist_sel=7 gives 0.
